// File: rtl/text_writer_if.sv
// Character-stream and text-buffer write bus for text_writer.
// master drives characters in; slave (the writer) drives buffer writes and cursor status.
interface text_writer_if #(
  parameter int h_disp = 1280,
  parameter int v_disp = 1024
);
  localparam int x_limit    = h_disp / 8;
  localparam int y_limit    = v_disp / 8;
  localparam int addr_width = $clog2(x_limit * y_limit);
  localparam int xw         = $clog2(x_limit);
  localparam int yw         = $clog2(y_limit);

  logic                  in_valid;
  logic [7:0]            in_char;
  logic                  in_ready;
  logic [addr_width-1:0] addr_write;
  logic                  write_enable;
  logic [7:0]            char_write;
  logic [xw-1:0]         cursor_x;
  logic [yw-1:0]         cursor_y;
  logic                  busy;

  modport master (
    output in_valid, in_char,
    input  in_ready, addr_write, write_enable, char_write, cursor_x, cursor_y, busy
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, addr_write, write_enable, char_write, cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/text_writer.sv
// Terminal-style text writer: turns a character stream into text-buffer writes
// with cursor tracking, control codes, and a full-screen clear on reset or form feed.
module text_writer #(
  parameter int h_disp = 1280,
  parameter int v_disp = 1024
) (
  input  logic          clk,
  input  logic          reset,
  text_writer_if.slave  bus
);
  localparam int x_limit    = h_disp / 8;
  localparam int y_limit    = v_disp / 8;
  localparam int cells      = x_limit * y_limit;
  localparam int addr_width = $clog2(cells);
  localparam int xw         = $clog2(x_limit);
  localparam int yw         = $clog2(y_limit);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;

  localparam logic [xw-1:0]         X_LAST   = xw'(x_limit - 1);
  localparam logic [yw-1:0]         Y_LAST   = yw'(y_limit - 1);
  localparam logic [addr_width-1:0] ROW_STEP = addr_width'(x_limit);
  // One bit wider than an address so the terminal count is representable for any geometry.
  localparam logic [addr_width:0]   CELLS    = (addr_width + 1)'(cells);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [xw-1:0]         cur_x;
  logic [yw-1:0]         cur_y;
  logic [addr_width-1:0] row_base;
  logic [addr_width-1:0] cur_addr;
  logic [addr_width:0]   clr_cnt;
  logic                  we_p1;
  logic [addr_width-1:0] addr_p1;
  logic [7:0]            char_p1;
  logic                  accept;
  logic [yw-1:0]         y_step;
  logic [addr_width-1:0] base_step;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  assign accept   = bus.in_valid && (state == IDLE);
  assign cur_addr = row_base + addr_width'(cur_x);

  // Row base is carried alongside the row index so no multiply sits on the write path.
  always_comb begin
    y_step    = cur_y + yw'(1);
    base_step = row_base + ROW_STEP;
    if (cur_y == Y_LAST) begin
      y_step    = '0;
      base_step = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && (bus.in_char == FF)) state_nxt = CLEAR;
      CLEAR: if (clr_cnt == CELLS)              state_nxt = IDLE;
    endcase
  end

  // Output stage: buffer write strobe, address and data are registered one cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      char_p1  <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      clr_cnt  <= '0;
    end else begin
      we_p1 <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_cnt != CELLS) begin
            we_p1   <= 1'b1;
            addr_p1 <= clr_cnt[addr_width-1:0];
            char_p1 <= SPACE;
            clr_cnt <= clr_cnt + (addr_width + 1)'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_printable(bus.in_char)) begin
              we_p1   <= 1'b1;
              addr_p1 <= cur_addr;
              char_p1 <= bus.in_char;
              if (cur_x == X_LAST) begin
                cur_x    <= '0;
                cur_y    <= y_step;
                row_base <= base_step;
              end else begin
                cur_x <= cur_x + xw'(1);
              end
            end else begin
              case (bus.in_char)
                LF: begin
                  cur_x    <= '0;
                  cur_y    <= y_step;
                  row_base <= base_step;
                end
                CR: cur_x <= '0;
                BS: begin
                  if (cur_x != '0) begin
                    cur_x   <= cur_x - xw'(1);
                    we_p1   <= 1'b1;
                    addr_p1 <= cur_addr - addr_width'(1);
                    char_p1 <= SPACE;
                  end
                end
                FF: begin
                  // The entry edge already issues the first clear write, so the count starts at one.
                  cur_x    <= '0;
                  cur_y    <= '0;
                  row_base <= '0;
                  we_p1    <= 1'b1;
                  addr_p1  <= '0;
                  char_p1  <= SPACE;
                  clr_cnt  <= (addr_width + 1)'(1);
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state == CLEAR);
  assign bus.write_enable = we_p1;
  assign bus.addr_write   = addr_p1;
  assign bus.char_write   = char_p1;
  assign bus.cursor_x     = cur_x;
  assign bus.cursor_y     = cur_y;
endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed and random character streams checked by a
// write scoreboard fed from a cursor-level reference model.
module tb_text_writer;
  localparam int XL = 160;
  localparam int YL = 128;
  localparam int N  = XL * YL;
  localparam int BOUND = 25000;

  logic clk;
  logic reset;
  int   cyc;

  text_writer_if #(.h_disp(1280), .v_disp(1024)) bus();

  text_writer #(.h_disp(1280), .v_disp(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_fail;
  int exp_q[$];
  int mx, my;
  int last_wr_cyc, prev_wr_cyc, last_addr, last_char;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    int act, e;
    forever begin
      @(negedge clk);
      if (bus.write_enable === 1'b1) begin
        n_checks++;
        act = int'(bus.addr_write) * 256 + int'(bus.char_write);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: addr=%0d char=0x%02h, required no write",
                   bus.addr_write, bus.char_write);
        end else begin
          e = exp_q.pop_front();
          if (e != act) begin
            n_fail++;
            $display("FAIL write: addr=%0d char=0x%02h, required addr=%0d char=0x%02h",
                     bus.addr_write, bus.char_write, e / 256, e % 256);
          end
        end
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        last_addr   = int'(bus.addr_write);
        last_char   = int'(bus.char_write);
      end
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < N; i++) exp_q.push_back(i * 256 + 32);
  endtask

  task automatic row_step();
    mx = 0;
    my = (my + 1) % YL;
  endtask

  task automatic model_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back((my * XL + mx) * 256 + int'(c));
      mx++;
      if (mx == XL) row_step();
    end else if (c == 8'h0A) begin
      row_step();
    end else if (c == 8'h0D) begin
      mx = 0;
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx--;
        exp_q.push_back((my * XL + mx) * 256 + 32);
      end
    end else if (c == 8'h0C) begin
      mx = 0;
      my = 0;
      push_clear();
    end
  endtask

  // Called between edges; holds the character until the DUT is ready, then lets one edge take it.
  task automatic send(input logic [7:0] c, output int waits);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    waits = 0;
    while (!bus.in_ready && waits < BOUND) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      model_accept(c);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (!bus.in_ready && cnt < BOUND) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.in_ready) chk("clear_timeout", 0, 1);
  endtask

  task automatic check_cursor(input string name);
    chk({name, "_x"}, int'(bus.cursor_x), mx);
    chk({name, "_y"}, int'(bus.cursor_y), my);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_we"},    int'(bus.write_enable), 0);
    chk({name, "_addr"},  int'(bus.addr_write), 0);
    chk({name, "_char"},  int'(bus.char_write), 0);
    chk({name, "_cx"},    int'(bus.cursor_x), 0);
    chk({name, "_cy"},    int'(bus.cursor_y), 0);
    chk({name, "_busy"},  int'(bus.busy), 1);
    chk({name, "_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic drain();
    idle(3);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w, cnt, r, k;
    logic [7:0] c;
    logic [7:0] others [12];
    others = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h09, 8'h0B, 8'h0E, 8'h10, 8'h1B, 8'h1F, 8'h11, 8'h05};
    n_checks = 0; n_fail = 0; cyc = 0;
    mx = 0; my = 0;
    last_wr_cyc = 0; prev_wr_cyc = 0; last_addr = -1; last_char = -1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");

    // Power-on clear
    @(posedge clk); #1;
    reset = 1'b0;
    push_clear();
    wait_idle(cnt);
    chk("init_clear_cycles", cnt, N + 1);
    chk("init_busy", int'(bus.busy), 0);
    chk("init_last_addr", last_addr, N - 1);
    check_cursor("init_cursor");
    chk("init_queue", exp_q.size(), 0);

    // Back-to-back printable characters
    send(8'h41, w);
    send(8'h42, w);
    idle(3);
    chk("ab_consecutive", last_wr_cyc - prev_wr_cyc, 1);
    chk("ab_cursor_x", int'(bus.cursor_x), 2);
    chk("ab_cursor_y", int'(bus.cursor_y), 0);
    drain();

    // Control codes around cursor (5,3)
    send(8'h0D, w);
    repeat (3) send(8'h0A, w);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), w);
    check_cursor("pos53");
    send(8'h08, w);
    idle(2);
    chk("bs_addr", last_addr, 484);
    chk("bs_char", last_char, 32);
    chk("bs_cursor_x", int'(bus.cursor_x), 4);
    send(8'h0D, w);
    check_cursor("cr");
    send(8'h0A, w);
    check_cursor("lf");
    send(8'h08, w);
    check_cursor("bs_at_x0");
    drain();

    // Bottom-right cell and wrap to top
    send(8'h0D, w);
    repeat (YL - 1 - my) send(8'h0A, w);
    for (int i = 0; i < XL - 1; i++) send(8'h30 + 8'(i % 10), w);
    chk("corner_x", int'(bus.cursor_x), XL - 1);
    chk("corner_y", int'(bus.cursor_y), YL - 1);
    send(8'h5A, w);
    idle(2);
    chk("corner_addr", last_addr, N - 1);
    chk("corner_char", last_char, 8'h5A);
    check_cursor("wrap");
    drain();

    // Random stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0A;
      else if (r < 84) c = 8'h0D;
      else if (r < 92) c = 8'h08;
      else if (r < 96) c = others[$urandom_range(0, 11)];
      else             c = 8'($urandom_range(127, 255));
      send(c, w);
      check_cursor("rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Form feed with next character already waiting
    send(8'h0C, w);
    send(8'h51, w);
    chk("ff_ready_wait", w, N);
    idle(2);
    chk("ff_q_addr", last_addr, 0);
    chk("ff_q_char", last_char, 8'h51);
    check_cursor("ff_cursor");
    drain();

    // Reset in the middle of a clear
    send(8'h0C, w);
    bus.in_valid = 1'b0;
    k = 0;
    while (!(bus.write_enable && int'(bus.addr_write) == 1000) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("midclear_reached", int'(bus.addr_write), 1000);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("midclear_reset");
    exp_q.delete();
    mx = 0; my = 0;
    repeat (2) @(negedge clk);
    chk("midclear_hold_we", int'(bus.write_enable), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_clear();
    wait_idle(cnt);
    chk("restart_clear_cycles", cnt, N + 1);
    chk("restart_busy", int'(bus.busy), 0);
    check_cursor("restart_cursor");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
